// File: rtl/ygr019_host_cmd_master.sv
// YGR019 host command initiator: clear CMOK, write CR1..CR4, poll HIRQREQ, read CR1..CR4 back.
// Optional poll-phase timeout is built in when YGR_HOST_TIMEOUT_EN is defined.
module ygr019_host_cmd_master #(
  parameter int POLL_GAP  = 4,
  parameter int TO_CYCLES = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_start,
  input  logic [15:0] i_cmd_cr1,
  input  logic [15:0] i_cmd_cr2,
  input  logic [15:0] i_cmd_cr3,
  input  logic [15:0] i_cmd_cr4,
  output logic        o_cmd_busy,
  output logic        o_cmd_done,
  output logic        o_cmd_to,
  output logic [15:0] o_rsp_cr1,
  output logic [15:0] o_rsp_cr2,
  output logic [15:0] o_rsp_cr3,
  output logic [15:0] o_rsp_cr4,
  output logic [5:0]  o_reg_a,
  output logic [15:0] o_reg_do,
  output logic        o_reg_we,
  output logic        o_reg_re,
  input  logic [15:0] i_reg_di,
  input  logic        i_reg_rdy
);

  localparam logic [5:0] A_HIRQ = 6'h08;
  localparam logic [5:0] A_CR1  = 6'h18;
  localparam logic [5:0] A_CR2  = 6'h1C;
  localparam logic [5:0] A_CR3  = 6'h20;
  localparam logic [5:0] A_CR4  = 6'h24;
  // The GAP state lasts POLL_GAP-1 cycles; the re-issue edge in POLL makes it POLL_GAP low cycles.
  localparam bit         GAP_SKIP = (POLL_GAP <= 1);
  localparam logic [7:0] GAP_LAST = (POLL_GAP > 1) ? 8'(POLL_GAP - 2) : 8'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_WCR1, S_WCR2, S_WCR3, S_WCR4, S_POLL, S_GAP,
    S_RCR1, S_RCR2, S_RCR3, S_RCR4, S_FIN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0][15:0] r_cmd, r_shadow;
  logic [7:0]       r_gap;
  logic             w_strobe, w_acc_done, w_acc_state, w_is_read, w_issue;
  logic             w_expired, w_abort, w_cmok;
  logic [5:0]       w_addr;
  logic [15:0]      w_wdata;

  assign w_strobe   = o_reg_we | o_reg_re;
  assign w_acc_done = w_strobe & i_reg_rdy;
  assign w_cmok     = i_reg_di[0];
  assign w_issue    = w_acc_state & ~w_strobe & ~((r_state == S_POLL) & w_expired);

  always_comb begin
    w_addr      = A_HIRQ;
    w_wdata     = 16'h0000;
    w_is_read   = 1'b0;
    w_acc_state = 1'b1;
    case (r_state)
      S_CLR:  w_wdata = 16'h3FFE;  // zero only in CMOK; other R/W0 flags untouched
      S_WCR1: begin w_addr = A_CR1; w_wdata = r_cmd[0]; end
      S_WCR2: begin w_addr = A_CR2; w_wdata = r_cmd[1]; end
      S_WCR3: begin w_addr = A_CR3; w_wdata = r_cmd[2]; end
      S_WCR4: begin w_addr = A_CR4; w_wdata = r_cmd[3]; end
      S_POLL: w_is_read = 1'b1;
      S_RCR1: begin w_addr = A_CR1; w_is_read = 1'b1; end
      S_RCR2: begin w_addr = A_CR2; w_is_read = 1'b1; end
      S_RCR3: begin w_addr = A_CR3; w_is_read = 1'b1; end
      S_RCR4: begin w_addr = A_CR4; w_is_read = 1'b1; end
      default: w_acc_state = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_cmd_start) w_state_nxt = S_CLR;
      S_CLR:  if (w_acc_done) w_state_nxt = S_WCR1;
      S_WCR1: if (w_acc_done) w_state_nxt = S_WCR2;
      S_WCR2: if (w_acc_done) w_state_nxt = S_WCR3;
      S_WCR3: if (w_acc_done) w_state_nxt = S_WCR4;
      S_WCR4: if (w_acc_done) w_state_nxt = S_POLL;
      S_POLL: begin
        if (w_acc_done) begin
          if (w_cmok)         w_state_nxt = S_RCR1;
          else if (w_expired) w_state_nxt = S_FIN;
          else if (GAP_SKIP)  w_state_nxt = S_POLL;
          else                w_state_nxt = S_GAP;
        end else if (!w_strobe && w_expired) begin
          w_state_nxt = S_FIN;
        end
      end
      S_GAP: begin
        if (w_expired)              w_state_nxt = S_FIN;
        else if (r_gap == GAP_LAST) w_state_nxt = S_POLL;
      end
      S_RCR1: if (w_acc_done) w_state_nxt = S_RCR2;
      S_RCR2: if (w_acc_done) w_state_nxt = S_RCR3;
      S_RCR3: if (w_acc_done) w_state_nxt = S_RCR4;
      S_RCR4: if (w_acc_done) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cmd_busy <= 1'b0;
      o_cmd_done <= 1'b0;
      o_reg_we   <= 1'b0;
      o_reg_re   <= 1'b0;
      o_reg_a    <= 6'h00;
      o_reg_do   <= 16'h0000;
      o_rsp_cr1  <= 16'h0000;
      o_rsp_cr2  <= 16'h0000;
      o_rsp_cr3  <= 16'h0000;
      o_rsp_cr4  <= 16'h0000;
      r_cmd      <= '0;
      r_shadow   <= '0;
      r_gap      <= 8'd0;
    end else begin
      o_cmd_done <= 1'b0;
      if (r_state == S_IDLE && i_cmd_start) begin
        r_cmd      <= {i_cmd_cr4, i_cmd_cr3, i_cmd_cr2, i_cmd_cr1};
        o_cmd_busy <= 1'b1;
      end
      // Strobe goes high only from a low cycle, so every access is preceded by an idle cycle.
      if (w_issue) begin
        o_reg_we <= ~w_is_read;
        o_reg_re <= w_is_read;
        o_reg_a  <= w_addr;
        o_reg_do <= w_wdata;
      end else if (w_acc_done) begin
        o_reg_we <= 1'b0;
        o_reg_re <= 1'b0;
      end
      if (w_acc_done) begin
        case (r_state)
          S_RCR1: r_shadow[0] <= i_reg_di;
          S_RCR2: r_shadow[1] <= i_reg_di;
          S_RCR3: r_shadow[2] <= i_reg_di;
          S_RCR4: r_shadow[3] <= i_reg_di;
          default: ;
        endcase
      end
      r_gap <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
      // Responses are published together with DONE so they stay stable between commands.
      if (r_state == S_FIN) begin
        o_cmd_done <= 1'b1;
        o_cmd_busy <= 1'b0;
        o_rsp_cr1  <= w_abort ? 16'hFFFF : r_shadow[0];
        o_rsp_cr2  <= w_abort ? 16'hFFFF : r_shadow[1];
        o_rsp_cr3  <= w_abort ? 16'hFFFF : r_shadow[2];
        o_rsp_cr4  <= w_abort ? 16'hFFFF : r_shadow[3];
      end
    end
  end

`ifdef YGR_HOST_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_to_flag, r_abort, r_cmd_to, w_in_poll, w_to_hit;

  assign w_in_poll = (r_state == S_POLL) || (r_state == S_GAP);
  assign w_to_hit  = w_in_poll && (r_to_cnt == 16'(TO_CYCLES));
  assign w_expired = r_to_flag | w_to_hit;
  assign w_abort   = r_abort;
  assign o_cmd_to  = r_cmd_to;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt  <= 16'd0;
      r_to_flag <= 1'b0;
      r_abort   <= 1'b0;
      r_cmd_to  <= 1'b0;
    end else begin
      if (r_state == S_WCR4 && w_acc_done) begin
        r_to_cnt  <= 16'd0;
        r_to_flag <= 1'b0;
      end else if (w_in_poll) begin
        r_to_cnt  <= r_to_cnt + 16'd1;
        r_to_flag <= r_to_flag | w_to_hit;
      end
      if (r_state == S_IDLE && i_cmd_start)        r_abort <= 1'b0;
      else if (w_in_poll && w_state_nxt == S_FIN)  r_abort <= 1'b1;
      if (r_state == S_FIN) r_cmd_to <= r_abort;
    end
  end
`else
  // Without the counter the poll loop only ends on CMOK or reset; the limit is inert.
  assign w_expired = 1'b0 & (TO_CYCLES == 0);
  assign w_abort   = 1'b0;
  assign o_cmd_to  = 1'b0;
`endif

endmodule

// File: tb/tb_ygr019_host_cmd_master.sv
// Bench for ygr019_host_cmd_master: behavioural register slave, access log and expected-sequence model.
module tb_ygr019_host_cmd_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0;
  logic [15:0] c1 = '0, c2 = '0, c3 = '0, c4 = '0;
  logic        busy, done, to_f, rwe, rre;
  logic [15:0] r1, r2, r3, r4, rdo;
  logic [5:0]  ra;
  logic        rdy = 1'b1;
  logic [15:0] di = '0;

  always #5 clk = ~clk;

  ygr019_host_cmd_master #(.POLL_GAP(4), .TO_CYCLES(50)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_start(start),
    .i_cmd_cr1(c1), .i_cmd_cr2(c2), .i_cmd_cr3(c3), .i_cmd_cr4(c4),
    .o_cmd_busy(busy), .o_cmd_done(done), .o_cmd_to(to_f),
    .o_rsp_cr1(r1), .o_rsp_cr2(r2), .o_rsp_cr3(r3), .o_rsp_cr4(r4),
    .o_reg_a(ra), .o_reg_do(rdo), .o_reg_we(rwe), .o_reg_re(rre),
    .i_reg_di(di), .i_reg_rdy(rdy));

  typedef struct { bit we; logic [5:0] a; logic [15:0] d; int cs; int cc; } acc_t;
  acc_t        log_q[$];
  acc_t        cur;
  int          n_chk = 0, n_err = 0;
  int          cyc = 0, viol = 0, dly = 0, cmok_poll = 1, npoll = 0, wcnt = 0;
  bit          pend = 0, last_done = 0;
  logic [15:0] cr_val[4];
  logic [3:0][15:0] rsp_w;
  assign rsp_w = {r4, r3, r2, r1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input bit we, input logic [5:0] a, input logic [15:0] d);
    return {9'd0, we, a, (we ? d : 16'h0000)};
  endfunction

  // Register slave: RDY after dly wait cycles, CMOK reported from the cmok_poll-th poll on.
  always @(negedge clk) begin
    int idx;
    cyc++;
    if (rwe && rre) viol++;
    if (rst) begin
      pend = 0; wcnt = 0; last_done = 0; rdy = 1'b1;
    end else begin
      if (pend && (!(rwe || rre) || ra != cur.a || rdo != cur.d || rwe != cur.we)) viol++;
      if (last_done && (rwe || rre)) viol++;
      last_done = 0;
      if (rwe || rre) begin
        if (!pend) begin cur.we = rwe; cur.a = ra; cur.d = rdo; cur.cs = cyc; end
        if (wcnt >= dly) begin
          rdy = 1'b1; pend = 0; wcnt = 0; last_done = 1;
          di = 16'($urandom);
          if (rre && ra == 6'h08) begin
            npoll++;
            di[0] = (cmok_poll != 0 && npoll >= cmok_poll);
          end else if (rre && ra >= 6'h18 && ra <= 6'h24) begin
            idx = (int'(ra) - 'h18) / 4;
            di = cr_val[idx];
          end
          cur.cc = cyc;
          log_q.push_back(cur);
        end else begin
          rdy = 1'b0; pend = 1; wcnt++;
        end
      end else begin
        rdy = (dly == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        di  = 16'($urandom);
      end
    end
  end

  task automatic run_cmd(input logic [15:0] w1, w2, w3, w4, input int d, input int cp,
                         input bit inj, input bit exp_to);
    logic [31:0] e[$];
    logic [15:0] wv[4];
    bit seen = 0;
    int lat = 0, bad = 0;
    wv[0] = w1; wv[1] = w2; wv[2] = w3; wv[3] = w4;
    @(posedge clk); #1;
    dly = d; cmok_poll = cp; npoll = 0; viol = 0; log_q.delete();
    for (int i = 0; i < 4; i++) cr_val[i] = 16'($urandom);
    c1 = w1; c2 = w2; c3 = w3; c4 = w4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c1 = 16'($urandom); c2 = 16'($urandom); c3 = 16'($urandom); c4 = 16'($urandom);
    for (int k = 1; k <= 3000; k++) begin
      start = inj && (k == 12);
      @(negedge clk);
      if (done) begin seen = 1; lat = k - 1; break; end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    if (seen) begin
      chk("cmd_to", 32'(to_f), 32'(exp_to));
      chk("busy_at_done", 32'(busy), 0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rsp_cr%0d", i + 1), 32'(rsp_w[i]), exp_to ? 32'hFFFF : 32'(cr_val[i]));
      if (d == 0 && cp == 1) chk("latency", 32'(lat), 21);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    e.push_back(pk(1, 6'h08, 16'h3FFE));
    for (int i = 0; i < 4; i++) e.push_back(pk(1, 6'(6'h18 + 4 * i), wv[i]));
    if (!exp_to) begin
      for (int p = 0; p < cp; p++) e.push_back(pk(0, 6'h08, 16'h0));
      for (int i = 0; i < 4; i++) e.push_back(pk(0, 6'(6'h18 + 4 * i), 16'h0));
      chk("n_access", 32'(log_q.size()), 32'(e.size()));
    end
    for (int i = 0; i < e.size() && i < log_q.size(); i++)
      chk($sformatf("acc%0d", i), pk(log_q[i].we, log_q[i].a, log_q[i].d), e[i]);
    if (exp_to) begin
      for (int i = 5; i < log_q.size(); i++)
        if (log_q[i].we || log_q[i].a != 6'h08) bad++;
      chk("to_polls_only", 32'(bad), 0);
      chk("to_has_polls", 32'(log_q.size() > 5), 1);
    end
    for (int i = 1; i < log_q.size(); i++)
      if (!log_q[i].we && log_q[i].a == 6'h08 && !log_q[i-1].we && log_q[i-1].a == 6'h08)
        chk("poll_gap", 32'(log_q[i].cs - log_q[i-1].cc - 1), 4);
    chk("bus_proto", 32'(viol), 0);
  endtask

  initial begin
    int dcnt;
    bit found;
    // Reset with RDY high: everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_to", 32'(to_f), 0);
    chk("rst_we", 32'(rwe), 0);
    chk("rst_re", 32'(rre), 0);
    chk("rst_a", 32'(ra), 0);
    chk("rst_do", 32'(rdo), 0);
    chk("rst_rsp", {r2, r1}, 0);
    chk("rst_rsp_hi", {r4, r3}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_cmd(16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0);
    run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 3, 0, 0);
    run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 5, 2, 1, 0);
    repeat (20) @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 0);

    // Reset while CR3 is being written.
    @(posedge clk); #1;
    dly = 3; cmok_poll = 1; npoll = 0;
    c1 = 16'h1111; c2 = 16'h2222; c3 = 16'h3333; c4 = 16'h4444; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rwe && ra == 6'h20) begin found = 1; break; end
    end
    chk("wcr3_reached", 32'(found), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_we", 32'(rwe), 0);
    chk("rst_mid_re", 32'(rre), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done || rwe || rre) dcnt++;
    end
    chk("rst_mid_quiet", 32'(dcnt), 0);
    run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, 1, 0, 0);

    for (int n = 0; n < 6; n++)
      run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 4), $urandom_range(1, 4), 0, 0);

`ifdef YGR_HOST_TIMEOUT_EN
    run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, 0, 1);
    run_cmd(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 2, 2, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
